// File: rtl/branch_predictor_if.sv
// Fetch-stage lookup, EX-stage update and statistics signals of the branch predictor.
interface branch_predictor_if #(
   parameter int unsigned STAT_W = 16
);
   // Fetch-stage lookup
   logic [31:0]       lookup_pc;
   logic              pred_hit;
   logic              pred_taken;
   logic [31:0]       pred_target;
   // EX-stage resolution
   logic              upd_en;
   logic [31:0]       upd_pc;
   logic              upd_taken;
   logic [31:0]       upd_target;
   logic              upd_mispredict;
   // Statistics
   logic [STAT_W-1:0] branch_cnt;
   logic [STAT_W-1:0] mispredict_cnt;

   // Core side: drives lookups and resolutions, observes predictions
   modport master (
      output lookup_pc, upd_en, upd_pc, upd_taken, upd_target, upd_mispredict,
      input  pred_hit, pred_taken, pred_target, branch_cnt, mispredict_cnt
   );

   // Predictor side
   modport slave (
      input  lookup_pc, upd_en, upd_pc, upd_taken, upd_target, upd_mispredict,
      output pred_hit, pred_taken, pred_target, branch_cnt, mispredict_cnt
   );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with optional bimodal 2-bit counters and
// saturating resolution statistics.
module branch_predictor #(
   parameter int unsigned ENTRIES = 16,
   parameter int unsigned MODE    = 1,   // 0: static not-taken, 1: bimodal
   parameter int unsigned STAT_W  = 16
) (
   input logic               CLK,
   input logic               nRST,
   branch_predictor_if.slave bp
);
   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned TAG_W = 32 - IDX_W - 2;
   localparam logic [STAT_W-1:0] STAT_ONE = 1;

   logic             r_valid  [ENTRIES];
   logic [TAG_W-1:0] r_tag    [ENTRIES];
   logic [31:0]      r_target [ENTRIES];
   logic [1:0]       r_ctr    [ENTRIES];

   logic [STAT_W-1:0] r_branch_cnt;
   logic [STAT_W-1:0] r_mispredict_cnt;

   logic [IDX_W-1:0] w_lk_idx;
   logic [TAG_W-1:0] w_lk_tag;
   logic             w_lk_hit;
   logic [IDX_W-1:0] w_up_idx;
   logic [TAG_W-1:0] w_up_tag;
   logic             w_up_hit;
   logic             w_unused;

   // Word-aligned PCs: the byte offset carries no information
   assign w_unused = ^{bp.lookup_pc[1:0], bp.upd_pc[1:0]};

   assign w_lk_idx = bp.lookup_pc[IDX_W+1:2];
   assign w_lk_tag = bp.lookup_pc[31:IDX_W+2];
   assign w_up_idx = bp.upd_pc[IDX_W+1:2];
   assign w_up_tag = bp.upd_pc[31:IDX_W+2];

   assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
   assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

   // Zero-latency lookup straight off the table registers, so a same-cycle
   // update is only visible from the following cycle
   always_comb begin
      bp.pred_hit    = w_lk_hit;
      bp.pred_taken  = 1'b0;
      bp.pred_target = '0;
      if (w_lk_hit) begin
         bp.pred_taken  = (MODE == 1) && r_ctr[w_lk_idx][1];
         bp.pred_target = r_target[w_lk_idx];
      end
   end

   // Table update: train on hits, allocate only on taken misses
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= 2'b01;
         end
      end else if ((MODE == 1) && bp.upd_en) begin
         if (w_up_hit) begin
            if (bp.upd_taken) begin
               if (r_ctr[w_up_idx] != 2'b11) r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 2'd1;
               r_target[w_up_idx] <= bp.upd_target;
            end else if (r_ctr[w_up_idx] != 2'b00) begin
               r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 2'd1;
            end
         end else if (bp.upd_taken) begin
            r_valid[w_up_idx]  <= 1'b1;
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= bp.upd_target;
            r_ctr[w_up_idx]    <= 2'b10;
         end
      end
   end

   // Saturating statistics counters
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_branch_cnt     <= '0;
         r_mispredict_cnt <= '0;
      end else if (bp.upd_en) begin
         if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + STAT_ONE;
         if (bp.upd_mispredict && (r_mispredict_cnt != '1)) begin
            r_mispredict_cnt <= r_mispredict_cnt + STAT_ONE;
         end
      end
   end

   assign bp.branch_cnt     = r_branch_cnt;
   assign bp.mispredict_cnt = r_mispredict_cnt;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: bimodal DUT, static DUT and a narrow-statistics DUT.
module tb_branch_predictor;
   logic CLK;
   logic nRST;
   int   total;
   int   bad;
   int   exp_bc;
   int   exp_mc;

   branch_predictor_if #(.STAT_W(16)) bp1 ();
   branch_predictor_if #(.STAT_W(16)) bp0 ();
   branch_predictor_if #(.STAT_W(4))  bp4 ();

   branch_predictor #(.ENTRIES(16), .MODE(1), .STAT_W(16)) dut1 (
      .CLK(CLK), .nRST(nRST), .bp(bp1)
   );
   branch_predictor #(.ENTRIES(16), .MODE(0), .STAT_W(16)) dut0 (
      .CLK(CLK), .nRST(nRST), .bp(bp0)
   );
   branch_predictor #(.ENTRIES(16), .MODE(1), .STAT_W(4)) dut4 (
      .CLK(CLK), .nRST(nRST), .bp(bp4)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic look(input logic [31:0] pc);
      bp1.lookup_pc = pc;
      #1;
   endtask

   // One resolved branch on the bimodal DUT
   task automatic upd1(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic mis);
      bp1.upd_pc         = pc;
      bp1.upd_taken      = tk;
      bp1.upd_target     = tgt;
      bp1.upd_mispredict = mis;
      bp1.upd_en         = 1'b1;
      tick();
      bp1.upd_en         = 1'b0;
      bp1.upd_mispredict = 1'b0;
      exp_bc++;
      if (mis) exp_mc++;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      exp_bc = 0;
      exp_mc = 0;
      nRST = 1'b0;
      bp1.lookup_pc = 32'h40; bp1.upd_en = 0; bp1.upd_pc = 0; bp1.upd_taken = 0;
      bp1.upd_target = 0; bp1.upd_mispredict = 0;
      bp0.lookup_pc = 32'h40; bp0.upd_en = 0; bp0.upd_pc = 0; bp0.upd_taken = 0;
      bp0.upd_target = 0; bp0.upd_mispredict = 0;
      bp4.lookup_pc = 32'h40; bp4.upd_en = 0; bp4.upd_pc = 0; bp4.upd_taken = 0;
      bp4.upd_target = 0; bp4.upd_mispredict = 0;
      #3;
      chk("rst_hit", {31'b0, bp1.pred_hit}, 32'd0);
      chk("rst_taken", {31'b0, bp1.pred_taken}, 32'd0);
      chk("rst_target", bp1.pred_target, 32'd0);
      chk("rst_bc", {16'b0, bp1.branch_cnt}, 32'd0);
      chk("rst_mc", {16'b0, bp1.mispredict_cnt}, 32'd0);
      tick();
      tick();
      nRST = 1'b1;
      tick();

      look(32'h40);
      chk("post_rst_hit", {31'b0, bp1.pred_hit}, 32'd0);
      chk("post_rst_target", bp1.pred_target, 32'd0);
      chk("post_rst_cnt0", {28'b0, bp4.branch_cnt}, 32'd0);

      // Allocate, then train down
      upd1(32'h40, 1'b1, 32'h80, 1'b1);
      look(32'h40);
      chk("alloc_hit", {31'b0, bp1.pred_hit}, 32'd1);
      chk("alloc_taken", {31'b0, bp1.pred_taken}, 32'd1);
      chk("alloc_target", bp1.pred_target, 32'h80);
      chk("alloc_bc", {16'b0, bp1.branch_cnt}, exp_bc);
      chk("alloc_mc", {16'b0, bp1.mispredict_cnt}, exp_mc);
      upd1(32'h40, 1'b0, 32'hDEAD, 1'b0);
      look(32'h40);
      chk("nt1_taken", {31'b0, bp1.pred_taken}, 32'd0);
      chk("nt1_target_kept", bp1.pred_target, 32'h80);
      upd1(32'h40, 1'b0, 32'h0, 1'b0);
      look(32'h40);
      chk("nt2_hit", {31'b0, bp1.pred_hit}, 32'd1);
      chk("nt2_taken", {31'b0, bp1.pred_taken}, 32'd0);
      // ctr floor: 00 stays 00, so one taken only reaches 01
      upd1(32'h40, 1'b0, 32'h0, 1'b0);
      upd1(32'h40, 1'b1, 32'h84, 1'b0);
      look(32'h40);
      chk("floor_taken", {31'b0, bp1.pred_taken}, 32'd0);
      chk("hit_taken_target", bp1.pred_target, 32'h84);

      // Alias on index 0
      upd1(32'h80, 1'b1, 32'h100, 1'b0);
      look(32'h40);
      chk("alias_old_hit", {31'b0, bp1.pred_hit}, 32'd0);
      chk("alias_old_target", bp1.pred_target, 32'd0);
      look(32'h80);
      chk("alias_new_hit", {31'b0, bp1.pred_hit}, 32'd1);
      chk("alias_new_taken", {31'b0, bp1.pred_taken}, 32'd1);
      chk("alias_new_target", bp1.pred_target, 32'h100);

      // Not-taken miss never allocates
      upd1(32'h4C, 1'b0, 32'h400, 1'b0);
      look(32'h4C);
      chk("nt_miss_noalloc", {31'b0, bp1.pred_hit}, 32'd0);

      // Ceiling: 10 -> 11 saturates, two not-taken bring it back to 01
      for (int i = 0; i < 5; i++) upd1(32'h44, 1'b1, 32'h200, 1'b0);
      upd1(32'h44, 1'b0, 32'h0, 1'b0);
      look(32'h44);
      chk("sat_taken", {31'b0, bp1.pred_taken}, 32'd1);
      upd1(32'h44, 1'b0, 32'h0, 1'b0);
      look(32'h44);
      chk("sat_then_nt", {31'b0, bp1.pred_taken}, 32'd0);

      // Same-cycle lookup and update of one index
      bp1.lookup_pc  = 32'h48;
      bp1.upd_pc     = 32'h48;
      bp1.upd_taken  = 1'b1;
      bp1.upd_target = 32'h300;
      bp1.upd_en     = 1'b1;
      #1;
      chk("same_cyc_before", {31'b0, bp1.pred_hit}, 32'd0);
      chk("same_cyc_before_tgt", bp1.pred_target, 32'd0);
      tick();
      bp1.upd_en = 1'b0;
      exp_bc++;
      #1;
      chk("same_cyc_after", {31'b0, bp1.pred_hit}, 32'd1);
      chk("same_cyc_after_tgt", bp1.pred_target, 32'h300);

      // Mispredict flag without upd_en is ignored
      bp1.upd_mispredict = 1'b1;
      tick();
      bp1.upd_mispredict = 1'b0;
      chk("mis_no_en_bc", {16'b0, bp1.branch_cnt}, exp_bc);
      chk("mis_no_en_mc", {16'b0, bp1.mispredict_cnt}, exp_mc);

      // Static DUT and narrow-statistics DUT in parallel
      bp0.upd_pc = 32'h40; bp0.upd_taken = 1'b1; bp0.upd_target = 32'h80; bp0.upd_en = 1'b1;
      bp4.upd_pc = 32'h44; bp4.upd_taken = 1'b1; bp4.upd_target = 32'h90;
      bp4.upd_mispredict = 1'b1; bp4.upd_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i == 9) begin
            chk("m0_mid_hit", {31'b0, bp0.pred_hit}, 32'd0);
            chk("m0_mid_taken", {31'b0, bp0.pred_taken}, 32'd0);
            chk("m0_mid_bc", {16'b0, bp0.branch_cnt}, 32'd10);
         end
      end
      bp0.upd_en = 1'b0;
      bp4.upd_en = 1'b0;
      bp4.upd_mispredict = 1'b0;
      #1;
      chk("m0_hit", {31'b0, bp0.pred_hit}, 32'd0);
      chk("m0_target", bp0.pred_target, 32'd0);
      chk("m0_bc", {16'b0, bp0.branch_cnt}, 32'd20);
      chk("s4_bc_sat", {28'b0, bp4.branch_cnt}, 32'd15);
      chk("s4_mc_sat", {28'b0, bp4.mispredict_cnt}, 32'd15);

      // Asynchronous reset mid-cycle, overlapping an update
      bp1.upd_pc = 32'h50; bp1.upd_taken = 1'b1; bp1.upd_target = 32'h500;
      bp1.upd_mispredict = 1'b1; bp1.upd_en = 1'b1;
      bp1.lookup_pc = 32'h48;
      nRST = 1'b0;
      #1;
      chk("arst_bc", {16'b0, bp1.branch_cnt}, 32'd0);
      chk("arst_mc", {16'b0, bp1.mispredict_cnt}, 32'd0);
      chk("arst_m0_bc", {16'b0, bp0.branch_cnt}, 32'd0);
      chk("arst_s4_bc", {28'b0, bp4.branch_cnt}, 32'd0);
      chk("arst_table_hit", {31'b0, bp1.pred_hit}, 32'd0);
      tick();
      bp1.upd_en = 1'b0;
      bp1.upd_mispredict = 1'b0;
      #1;
      nRST = 1'b1;
      tick();
      look(32'h50);
      chk("rst_wins_hit", {31'b0, bp1.pred_hit}, 32'd0);
      chk("rst_wins_bc", {16'b0, bp1.branch_cnt}, 32'd0);
      exp_bc = 0;
      exp_mc = 0;
      upd1(32'h50, 1'b1, 32'h500, 1'b0);
      look(32'h50);
      chk("post_arst_hit", {31'b0, bp1.pred_hit}, 32'd1);
      chk("post_arst_target", bp1.pred_target, 32'h500);
      chk("post_arst_bc", {16'b0, bp1.branch_cnt}, exp_bc);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
